mouse_cell_editor: RTL

- Sits directly downstream of the PS/2 mouse cell-select stage, between the mouse and the automaton board register file.
- Turns raw click levels and the selected cell index into clean, single-transfer edit commands using a valid/ack handshake, and turns right clicks into one-cycle step pulses.
- Supports click-to-toggle and click-drag painting.
- Applies a release hold-off so click bounce cannot issue duplicate edits.

---
 rtl/mouse_cell_editor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mouse_cell_editor.sv
`default_nettype none
// ============================================================================
// Module  : mouse_cell_editor
// Purpose : Turns mouse click levels into handshaked board edit commands
//           (toggle / drag-paint) and right clicks into single step pulses.
// Revision: 1.0
// ============================================================================
module mouse_cell_editor #(
    parameter int BOARD_HEIGHT   = 5,
    parameter int BOARD_LENGTH   = 5,
    parameter int NUM_CELLS      = BOARD_HEIGHT * BOARD_LENGTH,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        edit_enable,
    input  logic        left_click,
    input  logic        right_click,
    input  logic [10:0] mouse_cell,
    input  logic        board_busy,
    input  logic        edit_ack,
    output logic        edit_valid,
    output logic [10:0] edit_cell,
    output logic [1:0]  edit_op,
    output logic        step_pulse
);

    localparam int                  c_cnt_w     = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [10:0]         c_num_cells = 11'(NUM_CELLS);
    localparam logic [c_cnt_w-1:0]  c_holdoff   = c_cnt_w'(HOLDOFF_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [1:0]          c_op_toggle = 2'b11;
    localparam logic [1:0]          c_op_set    = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PEND    = 3'd1,
        S_ISSUE   = 3'd2,
        S_DRAG    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_l_q;
    logic                 r_l_prev;
    logic                 r_r_q;
    logic                 r_r_prev;
    logic [10:0]          r_cell_q;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [10:0]          r_cell;
    logic [10:0]          w_cell_nxt;
    logic [1:0]           r_op;
    logic [1:0]           w_op_nxt;
    logic                 r_step;
    logic                 w_step_nxt;

    logic w_l_rise;
    logic w_r_rise;
    logic w_in_range;
    logic w_xfer;

    assign w_l_rise   = r_l_q & ~r_l_prev;
    assign w_r_rise   = r_r_q & ~r_r_prev;
    assign w_in_range = (r_cell_q < c_num_cells);
    assign w_xfer     = r_valid & edit_ack;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_l_q    <= 1'b0;
            r_l_prev <= 1'b0;
            r_r_q    <= 1'b0;
            r_r_prev <= 1'b0;
            r_cell_q <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_cell   <= '0;
            r_op     <= 2'b00;
            r_step   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_l_q    <= left_click;
            r_l_prev <= r_l_q;
            r_r_q    <= right_click;
            r_r_prev <= r_r_q;
            r_cell_q <= mouse_cell;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_cell   <= w_cell_nxt;
            r_op     <= w_op_nxt;
            r_step   <= w_step_nxt;
        end
    end

    // r_cell doubles as the last issued cell while dragging.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_cell_nxt  = r_cell;
        w_op_nxt    = r_op;
        w_step_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_l_rise && edit_enable && w_in_range) begin
                    w_cell_nxt  = r_cell_q;
                    w_op_nxt    = c_op_toggle;
                    w_state_nxt = board_busy ? S_PEND : S_ISSUE;
                end else if (w_r_rise && !r_l_q) begin
                    w_step_nxt = 1'b1;
                end
            end
            S_PEND: begin
                if (!board_busy) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Offer starts one clock after entry and holds until accepted.
                if (w_xfer) begin
                    if (r_l_q && edit_enable) begin
                        w_state_nxt = S_DRAG;
                    end else begin
                        w_state_nxt = S_HOLDOFF;
                        w_cnt_nxt   = c_holdoff;
                    end
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            S_DRAG: begin
                if (!r_l_q || !edit_enable) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = c_holdoff;
                end else if ((r_cell_q != r_cell) && w_in_range) begin
                    w_cell_nxt  = r_cell_q;
                    w_op_nxt    = c_op_set;
                    w_state_nxt = board_busy ? S_PEND : S_ISSUE;
                end
            end
            S_HOLDOFF: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt <= c_cnt_one) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign edit_valid = r_valid;
    assign edit_cell  = r_cell;
    assign edit_op    = r_op;
    assign step_pulse = r_step;

endmodule
`default_nettype wire
